// File: rtl/parser_pkg.sv
// Shared parser rule definitions: rule image layout, dimensions, and the
// rule-config address encoding used by both this loader and the slave decode.
package parser_pkg;

  localparam int TYPE_NUM          = 4;
  localparam int TYPE_WIDTH        = 16;
  localparam int TYPE_OFFSET_WIDTH = 8;
  localparam int KEY_FILED_NUM     = 8;
  localparam int KEY_OFFSET_WIDTH  = 8;
  localparam int HEAD_SHIFT_WIDTH  = 8;
  localparam int META_SHIFT_WIDTH  = 8;
  localparam int RULE_NUM          = 32;
  localparam int RULE_ID_W         = $clog2(RULE_NUM);

  // Loader index counter must cover the longest per-state write run.
  localparam int MAX_IDX    = (TYPE_NUM > KEY_FILED_NUM) ? TYPE_NUM : KEY_FILED_NUM;
  localparam int IDX_W      = $clog2(MAX_IDX);
  localparam int TYPE_IDX_W = $clog2(TYPE_NUM);
  localparam int KEY_IDX_W  = $clog2(KEY_FILED_NUM);

  // keyOffset entries carry a valid flag in bit KEY_OFFSET_WIDTH above the offset.
  typedef struct packed {
    logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]        typeRule_typeData;
    logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]        typeRule_typeMask;
    logic [TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0] typeRule_typeOffset;
    logic [KEY_FILED_NUM-1:0][KEY_OFFSET_WIDTH:0] typeRule_keyOffset;
    logic [KEY_FILED_NUM-1:0][KEY_OFFSET_WIDTH:0] typeRule_keyReplaceOffset;
    logic [HEAD_SHIFT_WIDTH-1:0]                typeRule_headShift;
    logic [META_SHIFT_WIDTH-1:0]                typeRule_metaShift;
  } type_rule_t;

  typedef enum logic [2:0] {
    INFO_COMMIT = 3'd0,
    INFO_TYPE   = 3'd1,
    INFO_TOFF   = 3'd2,
    INFO_KEY    = 3'd3,
    INFO_HEAD   = 3'd4,
    INFO_META   = 3'd5
  } conf_info_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_TYPE, ST_TOFF, ST_KEY, ST_HEAD, ST_META, ST_COMMIT, ST_DONE
  } loader_state_e;

  // Low 11 address bits: {info type, 3'b0, word id}.
  function automatic logic [10:0] conf_addr(input conf_info_e info, input logic [4:0] id);
    return {info, 3'b000, id};
  endfunction

endpackage

// File: rtl/rule_conf_loader.sv
// Serialises one type_rule_t into the 32-bit rule-write stream. Staging words
// are written first (type, type offset, key, head, meta), then a commit word
// latches the rule into the slave's slot. Invalidation issues only the commit.
module rule_conf_loader
  import parser_pkg::*;
#(
  parameter logic [20:0] ADDR_HI    = 21'd0,
  parameter int          GAP_CYCLES = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  type_rule_t           i_req_rule,
  input  logic [RULE_ID_W-1:0] i_req_rule_id,
  input  logic                 i_req_rule_valid,
  input  logic                 i_bus_grant,
  output logic                 o_rule_wren,
  output logic [31:0]          o_rule_wdata,
  output logic [31:0]          o_rule_addr,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int GAP_W = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);

  loader_state_e        state_reg, state_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [GAP_W-1:0]     gap_reg;
  type_rule_t           rule_reg;
  logic [RULE_ID_W-1:0] rule_id_reg;
  logic                 rule_valid_reg;

  logic                 write_en;
  logic                 can_write;
  logic                 done_next;
  conf_info_e           word_info;
  logic [4:0]           word_id;
  logic [31:0]          word_data;
  logic [TYPE_IDX_W-1:0] type_idx;
  logic [KEY_IDX_W-1:0]  key_idx;

  // The replace offsets belong to a different config path and are never sent.
  logic unused_key_replace;
  assign unused_key_replace = ^rule_reg.typeRule_keyReplaceOffset;

  assign type_idx    = idx_reg[TYPE_IDX_W-1:0];
  assign key_idx     = idx_reg[KEY_IDX_W-1:0];
  assign can_write   = i_bus_grant && (gap_reg == '0);
  assign o_req_ready = (state_reg == ST_IDLE);

  // Next-state, index advance and the word mux for the current state.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    write_en   = 1'b0;
    done_next  = 1'b0;
    word_info  = INFO_COMMIT;
    word_id    = '0;
    word_data  = '0;
    case (state_reg)
      ST_IDLE: begin
        idx_next = '0;
        if (i_req_valid) state_next = i_req_rule_valid ? ST_TYPE : ST_COMMIT;
      end
      ST_TYPE: begin
        word_info = INFO_TYPE;
        word_id   = 5'(idx_reg);
        word_data[16 +: TYPE_WIDTH] = rule_reg.typeRule_typeData[type_idx];
        word_data[0 +: TYPE_WIDTH]  = rule_reg.typeRule_typeMask[type_idx];
        if (can_write) begin
          write_en = 1'b1;
          if (idx_reg == IDX_W'(TYPE_NUM - 1)) begin
            state_next = ST_TOFF;
            idx_next   = '0;
          end else idx_next = idx_reg + IDX_W'(1);
        end
      end
      ST_TOFF: begin
        word_info = INFO_TOFF;
        word_id   = 5'(idx_reg);
        word_data[0 +: TYPE_OFFSET_WIDTH] = rule_reg.typeRule_typeOffset[type_idx];
        if (can_write) begin
          write_en = 1'b1;
          if (idx_reg == IDX_W'(TYPE_NUM - 1)) begin
            state_next = ST_KEY;
            idx_next   = '0;
          end else idx_next = idx_reg + IDX_W'(1);
        end
      end
      ST_KEY: begin
        word_info = INFO_KEY;
        word_id   = 5'(idx_reg);
        word_data[16] = rule_reg.typeRule_keyOffset[key_idx][KEY_OFFSET_WIDTH];
        word_data[0 +: KEY_OFFSET_WIDTH] =
          rule_reg.typeRule_keyOffset[key_idx][KEY_OFFSET_WIDTH-1:0];
        if (can_write) begin
          write_en = 1'b1;
          if (idx_reg == IDX_W'(KEY_FILED_NUM - 1)) begin
            state_next = ST_HEAD;
            idx_next   = '0;
          end else idx_next = idx_reg + IDX_W'(1);
        end
      end
      ST_HEAD: begin
        word_info = INFO_HEAD;
        word_data[0 +: HEAD_SHIFT_WIDTH] = rule_reg.typeRule_headShift;
        if (can_write) begin
          write_en   = 1'b1;
          state_next = ST_META;
        end
      end
      ST_META: begin
        word_info = INFO_META;
        word_data[0 +: META_SHIFT_WIDTH] = rule_reg.typeRule_metaShift;
        if (can_write) begin
          write_en   = 1'b1;
          state_next = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        word_info    = INFO_COMMIT;
        word_id      = 5'(rule_id_reg);
        word_data[0] = rule_valid_reg;
        if (can_write) begin
          write_en   = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done_next  = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, counters, request holding registers and registered write outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg      <= ST_IDLE;
      idx_reg        <= '0;
      gap_reg        <= '0;
      rule_reg       <= '0;
      rule_id_reg    <= '0;
      rule_valid_reg <= 1'b0;
      o_rule_wren    <= 1'b0;
      o_rule_wdata   <= '0;
      o_rule_addr    <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      if (state_reg == ST_IDLE && i_req_valid) begin
        rule_reg       <= i_req_rule;
        rule_id_reg    <= i_req_rule_id;
        rule_valid_reg <= i_req_rule_valid;
      end
      if (write_en) gap_reg <= GAP_W'(GAP_CYCLES);
      else if (gap_reg != '0) gap_reg <= gap_reg - GAP_W'(1);
      o_rule_wren <= write_en;
      if (write_en) begin
        o_rule_wdata <= word_data;
        o_rule_addr  <= {ADDR_HI, conf_addr(word_info, word_id)};
      end
      o_busy <= (state_next != ST_IDLE);
      o_done <= done_next;
    end
  end

endmodule
